// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared ALU arbiter.
// Lane n of every packed array belongs to requester n.
interface alu_share_arbiter_if #(
  parameter int NUM_LANES = 2,
  parameter int VEC_W     = 32
);
  logic [NUM_LANES-1:0]            req_valid_i;
  logic [NUM_LANES-1:0]            req_ready_o;
  logic [NUM_LANES-1:0][VEC_W-1:0] req_data1_i;
  logic [NUM_LANES-1:0][VEC_W-1:0] req_data2_i;
  logic [NUM_LANES-1:0][2:0]       req_ctrl_i;
  logic [NUM_LANES-1:0]            rsp_valid_o;
  logic [NUM_LANES-1:0]            rsp_ready_i;
  logic [NUM_LANES-1:0][VEC_W-1:0] rsp_data_o;
  logic [NUM_LANES-1:0]            rsp_zero_o;
  logic [NUM_LANES-1:0]            rsp_err_o;

  modport master (
    output req_valid_i, req_data1_i, req_data2_i, req_ctrl_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_data1_i, req_data2_i, req_ctrl_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_err_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ADD/SUB/OR/AND/MUL ALU between two
// requesters, with a multi-cycle MUL and one registered response slot each.
module alu_rsp_slot #(
  parameter int VEC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr,
  input  logic             rd,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             wr_zero,
  input  logic             wr_err,
  output logic             vld,
  output logic [VEC_W-1:0] data,
  output logic             zero,
  output logic             err
);
  // A write wins over a consume so back-to-back results keep the slot full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld  <= 1'b0;
      data <= '0;
      zero <= 1'b0;
      err  <= 1'b0;
    end else if (wr) begin
      vld  <= 1'b1;
      data <= wr_data;
      zero <= wr_zero;
      err  <= wr_err;
    end else if (rd) begin
      vld  <= 1'b0;
    end
  end
endmodule

module alu_share_arbiter #(
  parameter int MUL_LAT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_share_arbiter_if.slave   bus
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 32;
  localparam logic [2:0] OP_ADD = 3'b010, OP_SUB = 3'b110, OP_OR = 3'b001,
                         OP_AND = 3'b000, OP_MUL = 3'b100;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                          state;
  logic [3:0]                      cnt;
  logic                            last;
  logic [VEC_W-1:0]                mul_a, mul_b;
  logic                            mul_id;

  logic [NUM_LANES-1:0]            elig, grant, wr;
  logic                            acc, gid, go_busy, mul_done;
  logic [2:0]                      gop;
  logic [VEC_W-1:0]                ga, gb, alu_res, wr_data;
  logic                            alu_err, wr_err, wr_zero;

  logic [NUM_LANES-1:0]            rsp_valid, rsp_zero, rsp_err;
  logic [NUM_LANES-1:0][VEC_W-1:0] rsp_data;

  always_comb begin
    elig = '0;
    for (int n = 0; n < NUM_LANES; n++)
      elig[n] = !rst_i && (state == IDLE) && bus.req_valid_i[n] &&
                (!rsp_valid[n] || bus.rsp_ready_i[n]);
    grant = (&elig) ? (last ? 2'b01 : 2'b10) : elig;
  end

  assign acc = |grant;
  assign gid = grant[1];
  assign gop = bus.req_ctrl_i[gid];
  assign ga  = bus.req_data1_i[gid];
  assign gb  = bus.req_data2_i[gid];

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (gop)
      OP_ADD:  alu_res = ga + gb;
      OP_SUB:  alu_res = ga - gb;
      OP_OR:   alu_res = ga | gb;
      OP_AND:  alu_res = ga & gb;
      OP_MUL:  alu_res = ga * gb;
      default: alu_err = 1'b1;
    endcase
  end

  // With MUL_LAT == 1 the product goes straight to the slot like any other op.
  assign go_busy  = acc && (gop == OP_MUL) && (MUL_LAT > 1);
  assign mul_done = (state == BUSY) && (cnt == 4'd1);

  always_comb begin
    wr      = '0;
    wr_data = '0;
    wr_err  = 1'b0;
    if (mul_done) begin
      wr[mul_id] = 1'b1;
      wr_data    = mul_a * mul_b;
    end else if (acc && !go_busy) begin
      wr      = grant;
      wr_data = alu_res;
      wr_err  = alu_err;
    end
  end
  assign wr_zero = !wr_err && (wr_data == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      mul_a  <= '0;
      mul_b  <= '0;
      mul_id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          last <= gid;
          if (go_busy) begin
            state  <= BUSY;
            cnt    <= CNT_INIT;
            mul_a  <= ga;
            mul_b  <= gb;
            mul_id <= gid;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_slot
    alu_rsp_slot #(.VEC_W(VEC_W)) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr      (wr[n]),
      .rd      (bus.rsp_ready_i[n]),
      .wr_data (wr_data),
      .wr_zero (wr_zero),
      .wr_err  (wr_err),
      .vld     (rsp_valid[n]),
      .data    (rsp_data[n]),
      .zero    (rsp_zero[n]),
      .err     (rsp_err[n])
    );
  end

  assign bus.req_ready_o = grant;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_zero_o  = rsp_zero;
  assign bus.rsp_err_o   = rsp_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a transaction-level model
// of the slots, the MUL occupancy window and the round-robin pointer.
module tb_alu_share_arbiter;
  localparam int MUL_LAT = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  alu_share_arbiter_if bus ();

  alu_share_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic        m_vld [2];
  logic [31:0] m_data[2];
  logic        m_zero[2];
  logic        m_err [2];
  int          m_busy;       // cycles the ALU is still occupied by a MUL
  logic [31:0] m_pres;
  int          m_pid;
  logic        m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic e);
    longint unsigned p;
    e = 1'b0;
    r = 32'h0;
    case (op)
      3'b010: r = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'b110: r = 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
      3'b001: r = a | b;
      3'b000: r = a & b;
      3'b100: begin p = longint'(a) * longint'(b); r = p[31:0]; end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_vld[n] = 1'b0; m_data[n] = 32'h0; m_zero[n] = 1'b0; m_err[n] = 1'b0;
    end
    m_busy = 0; m_pres = 32'h0; m_pid = 0; m_last = 1'b1;
  endtask

  task automatic slot_write(input int id, input logic [31:0] r, input logic e);
    m_vld[id]  = 1'b1;
    m_data[id] = r;
    m_err[id]  = e;
    m_zero[id] = !e && (r == 32'h0);
  endtask

  function automatic logic [1:0] exp_grant();
    logic [1:0] el;
    if (rst_i || m_busy != 0) return 2'b00;
    for (int n = 0; n < 2; n++)
      el[n] = bus.req_valid_i[n] && (!m_vld[n] || bus.rsp_ready_i[n]);
    if (el == 2'b11) return m_last ? 2'b01 : 2'b10;
    return el;
  endfunction

  // Check the current cycle at the falling edge, then advance the model.
  task automatic step();
    logic [1:0]  g;
    logic [31:0] r;
    logic        e;
    int          id;
    @(negedge clk_i);
    g = exp_grant();
    chk("req_ready", 32'(bus.req_ready_o), 32'(g));
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("rsp_valid%0d", n), 32'(bus.rsp_valid_o[n]), 32'(m_vld[n]));
      chk($sformatf("rsp_data%0d", n),  bus.rsp_data_o[n],       m_data[n]);
      chk($sformatf("rsp_zero%0d", n),  32'(bus.rsp_zero_o[n]),  32'(m_zero[n]));
      chk($sformatf("rsp_err%0d", n),   32'(bus.rsp_err_o[n]),   32'(m_err[n]));
    end
    if (rst_i) model_reset();
    else begin
      for (int n = 0; n < 2; n++) if (bus.rsp_ready_i[n]) m_vld[n] = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) slot_write(m_pid, m_pres, 1'b0);
      end else if (g != 2'b00) begin
        id = g[1] ? 1 : 0;
        ref_alu(bus.req_ctrl_i[id], bus.req_data1_i[id], bus.req_data2_i[id], r, e);
        m_last = g[1];
        if (bus.req_ctrl_i[id] == 3'b100 && MUL_LAT > 1) begin
          m_busy = MUL_LAT - 1; m_pres = r; m_pid = id;
        end else slot_write(id, r, e);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_ctrl_i[id]  = op;
    bus.req_data1_i[id] = a;
    bus.req_data2_i[id] = b;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 7));
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b11;
    set_req(0, 3'b010, 32'h1, 32'h1);
    set_req(1, 3'b010, 32'h1, 32'h1);
    @(posedge clk_i); #1;
    step();                                 // reset held with both requesting
    rst_i = 1'b0;

    // ADD 5 + 3 on requester 0
    bus.req_valid_i = 2'b01;
    set_req(0, 3'b010, 32'h5, 32'h3);
    step();
    chk("add_result", bus.rsp_data_o[0], 32'h8);
    bus.req_valid_i = 2'b00;
    step();

    // alternating SUBs after reset: 0-1 and 7-7
    do_reset();
    bus.req_valid_i = 2'b11;
    set_req(0, 3'b110, 32'h0, 32'h1);
    set_req(1, 3'b110, 32'h7, 32'h7);
    for (int i = 0; i < 4; i++) step();
    chk("sub_wrap",  bus.rsp_data_o[0], 32'hFFFF_FFFF);
    chk("sub_zero1", 32'(bus.rsp_zero_o[1]), 32'h1);

    // MUL on requester 0 with requester 1 waiting; operands scrambled mid-flight
    do_reset();
    set_req(0, 3'b100, 32'h0001_0000, 32'h0001_0001);
    set_req(1, 3'b010, 32'h2, 32'h2);
    step();
    bus.req_valid_i = 2'b10;
    set_req(0, 3'b100, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 0; i < MUL_LAT - 1; i++) step();
    chk("mul_result", bus.rsp_data_o[0], 32'h0001_0000);
    step();

    // illegal op on requester 1
    bus.req_valid_i = 2'b10;
    set_req(1, 3'b111, 32'h5, 32'h5);
    step();
    chk("illegal_err", 32'(bus.rsp_err_o[1]), 32'h1);
    bus.req_valid_i = 2'b00;
    step();

    // back-pressure on slot 0, then release with a same-cycle refill
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b10;
    set_req(0, 3'b001, 32'hF0, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      step();
      set_req(0, 3'b000, $urandom, $urandom);
    end
    bus.rsp_ready_i = 2'b11;
    for (int i = 0; i < 2; i++) step();

    // reset one cycle after a MUL is accepted
    bus.req_valid_i = 2'b01;
    set_req(0, 3'b100, 32'h3, 32'h3);
    step();
    bus.req_valid_i = 2'b00;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    bus.req_valid_i = 2'b11;
    step();
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < MUL_LAT + 1; i++) step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      bus.req_valid_i = 2'($urandom_range(0, 3));
      for (int n = 0; n < 2; n++) begin
        set_req(n, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        bus.rsp_ready_i[n] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU (ADD/SUB/OR/AND/MUL) between two requesters, e.g. the EX stage and a side-band address unit.
- Uses round-robin arbitration and valid/ready handshakes on both the request and response sides.
- Single-cycle ops complete in one cycle. MUL occupies the ALU for MUL_LAT cycles.
- Each requester has its own registered response slot, held until that requester consumes it.

Parameters:
MUL_LAT, 3, cycles from MUL acceptance to its response valid; legal range 1..15.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset, synchronous, active-high
req_valid_i  input  2  bit n: requester n presents an operation
req_ready_o  output  2  bit n: grant; the operation is accepted when valid and ready are both high
req_data1_i  input  64  operand 1; requester n uses bits [32n+31:32n]
req_data2_i  input  64  operand 2; same packing as req_data1_i
req_ctrl_i  input  6  op code; requester n uses bits [3n+2:3n]
rsp_valid_o  output  2  bit n: response slot n holds a result
rsp_ready_i  input  2  bit n: requester n consumes its slot
rsp_data_o  output  64  result per requester; same packing as req_data1_i
rsp_zero_o  output  2  bit n: result n == 0 for a legal op
rsp_err_o  output  2  bit n: op code was illegal

Behaviour:
- Op codes: 010 ADD, 110 SUB, 001 OR, 000 AND, 100 MUL. All other codes are illegal.
- Arithmetic is modulo 2^32. MUL returns the low 32 bits of the unsigned product. SUB wraps, e.g. 0 - 1 = 0xFFFFFFFF.
- FSM has two states:
  - IDLE: grants are allowed.
  - BUSY: a MUL is in flight; down-counter loaded with MUL_LAT-1.
  - BUSY -> IDLE when the counter reaches 0; the MUL result is written to its slot on that edge.
- No grants are issued in BUSY.
- Eligibility: requester n is eligible when state == IDLE, req_valid_i[n] == 1, and slot n is free. Slot n is free when rsp_valid_o[n] == 0 or rsp_ready_i[n] == 1 in the same cycle.
- req_ready_o is combinational and one-hot or zero; at most one grant per cycle.
- Round-robin: a 1-bit pointer `last` records the last granted requester.
  - If both requesters are eligible, grant the one that is not `last`.
  - If only one is eligible, grant it.
  - `last` updates only on acceptance.
- Latency, for an operation accepted at edge N:
  - Legal non-MUL, or MUL with MUL_LAT == 1: rsp_valid_o[n] = 1 after edge N+1.
  - MUL with MUL_LAT > 1: enter BUSY at edge N+1 with operands, requester id and op latched; response valid after edge N+MUL_LAT.
  - Illegal op: response after edge N+1 with data = 0, err = 1, zero = 0. Illegal ops never enter BUSY.
- Response hold: while rsp_valid_o[n] == 1 and rsp_ready_i[n] == 0, slot n's data, zero and err stay stable.
  - On consume with no new write: valid -> 0.
  - On consume with a same-cycle write: valid stays 1 and the slot takes the new result.
- Operands are sampled only at the acceptance edge. Later changes on req_* do not affect an in-flight MUL.
- zero and err are registered together with data.
- Reset values: rsp_valid_o = 00, rsp_data_o = 0, rsp_zero_o = 00, rsp_err_o = 00, state = IDLE, counter = 0, `last` = 1 (requester 0 wins the first contention).
- req_ready_o = 00 whenever rst_i is high.
- Reset mid-MUL: the in-flight result is discarded and no response is produced.
- Slot n full and not consumed: requester n is not granted; the other requester may still be granted.

Test Plan:
- Requester 0 ADD 0x00000005 + 0x00000003, rsp_ready_i = 11 -> granted in the same cycle; one cycle later rsp_valid_o[0] = 1, data 0x00000008, zero 0, err 0.
- Both requesters hold valid SUB ops continuously after reset, rsp_ready_i = 11 -> grants alternate 0, 1, 0, 1. Requester 1 computing 7 - 7 returns data 0, zero 1. Requester 0 computing 0 - 1 returns 0xFFFFFFFF.
- Requester 0 MUL 0x00010000 * 0x00010001 with MUL_LAT = 3 -> response 3 cycles after acceptance, data 0x00010000. Requester 1 stays valid during the MUL -> no grant for 2 cycles, then granted.
- Requester 1 op code 111 -> response one cycle later with err 1, zero 0, data 0.
- rsp_ready_i[0] = 0 after a response -> slot 0 data stays stable and req_ready_o[0] = 0. Raise rsp_ready_i[0] -> requester 0 is granted in the same cycle, valid stays 1 and the slot takes the new data.
- Assert rst_i one cycle after a MUL is accepted -> no response, outputs return to reset values, and the next contention grants requester 0.
